hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage DataCycle datapath: drives stall/flush of PC, IF/ID, ID/EX, EX/MEM, MEM/WB.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_sat_counter.sv | 24 ++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the DataCycle pipeline hazard controller:
// FSM states, MP0 program-counter select codes and the hard-wired zero register.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEMWAIT  = 2'd1,
    ST_BRSHADOW = 2'd2
  } state_t;

  localparam logic [1:0] PCSEL_PC4 = 2'd0;
  localparam logic [1:0] PCSEL_REG = 2'd1;
  localparam logic [1:0] PCSEL_IMM = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with enable.
// The count sticks at all-ones instead of wrapping to zero.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage DataCycle datapath: memory-wait freeze,
// branch-redirect flushes with a fetch shadow, and load-use stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int BR_SHADOW   = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rx_idx,
  input  logic [4:0]       id_ry_idx,
  input  logic             id_uses_rx,
  input  logic             id_uses_ry,
  input  logic [4:0]       ex_rz_idx,
  input  logic             ex_memread,
  input  logic             ex_rin,
  input  logic [1:0]       mem_pc_sel,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             stall_idex,
  output logic             flush_idex,
  output logic             stall_exmem,
  output logic             flush_exmem,
  output logic             flush_memwb,
  output logic [1:0]       state_o,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [15:0] LP_TIMEOUT    = 16'(MEM_TIMEOUT);
  localparam logic [2:0]  LP_SHADOW     = 3'(BR_SHADOW);
  localparam bit          LP_HAS_SHADOW = (BR_SHADOW > 0);

  state_t      r_state;
  logic [15:0] r_wait_cnt;
  logic [2:0]  r_sh_cnt;
  logic        r_err_timeout;

  logic w_in_wait;
  logic w_in_shadow;
  logic w_freeze;
  logic w_timeout;
  logic w_redirect;
  logic w_rx_hit;
  logic w_ry_hit;
  logic w_load_use;

  assign w_in_wait   = (r_state == ST_MEMWAIT);
  assign w_in_shadow = (r_state == ST_BRSHADOW);

  // Once waiting, only the ack (or the timeout) ends the freeze.
  assign w_timeout = w_in_wait && !mem_ack && (r_wait_cnt == LP_TIMEOUT);
  assign w_freeze  = w_in_wait ? (!mem_ack && !w_timeout) : (mem_req && !mem_ack);

  assign w_redirect = !w_freeze && (mem_pc_sel != PCSEL_PC4);

  assign w_rx_hit = id_uses_rx && (id_rx_idx == ex_rz_idx);
  assign w_ry_hit = id_uses_ry && (id_ry_idx == ex_rz_idx);

  // ID is wrong-path during a redirect and a bubble during the shadow.
  assign w_load_use = !w_freeze && !w_redirect && !w_in_shadow &&
                      ex_memread && ex_rin && (ex_rz_idx != REG_ZERO) &&
                      (w_rx_hit || w_ry_hit);

  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    stall_idex  = 1'b0;
    flush_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    if (rst) begin
      stall_pc    = w_freeze || w_load_use;
      stall_ifid  = w_freeze || w_load_use;
      flush_ifid  = w_redirect || (w_in_shadow && !w_freeze);
      stall_idex  = w_freeze;
      flush_idex  = w_redirect || w_load_use;
      stall_exmem = w_freeze;
      flush_exmem = w_redirect;
      flush_memwb = w_freeze;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= 16'd0;
      r_sh_cnt      <= 3'd0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
      if (w_freeze) begin
        r_state    <= ST_MEMWAIT;
        r_wait_cnt <= w_in_wait ? (r_wait_cnt + 16'd1) : 16'd1;
        r_sh_cnt   <= 3'd0;
      end else if (w_redirect) begin
        r_state    <= LP_HAS_SHADOW ? ST_BRSHADOW : ST_RUN;
        r_wait_cnt <= 16'd0;
        r_sh_cnt   <= LP_SHADOW;
      end else if (w_in_shadow && (r_sh_cnt > 3'd1)) begin
        r_state    <= ST_BRSHADOW;
        r_wait_cnt <= 16'd0;
        r_sh_cnt   <= r_sh_cnt - 3'd1;
      end else begin
        r_state    <= ST_RUN;
        r_wait_cnt <= 16'd0;
        r_sh_cnt   <= 3'd0;
      end
    end
  end

  assign state_o     = r_state;
  assign err_timeout = r_err_timeout;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (stall_pc),
    .o_count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected control vectors are queued per step
// and compared against the DUT half a cycle later.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [4:0]       id_rx_idx = '0;
  logic [4:0]       id_ry_idx = '0;
  logic             id_uses_rx = 1'b0;
  logic             id_uses_ry = 1'b0;
  logic [4:0]       ex_rz_idx = '0;
  logic             ex_memread = 1'b0;
  logic             ex_rin = 1'b0;
  logic [1:0]       mem_pc_sel = '0;
  logic             mem_req = 1'b0;
  logic             mem_ack = 1'b0;
  logic             stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex;
  logic             stall_exmem, flush_exmem, flush_memwb;
  logic [1:0]       state_o;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .BR_SHADOW   (1),
    .MEM_TIMEOUT (8),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rx_idx    (id_rx_idx),
    .id_ry_idx    (id_ry_idx),
    .id_uses_rx   (id_uses_rx),
    .id_uses_ry   (id_uses_ry),
    .ex_rz_idx    (ex_rz_idx),
    .ex_memread   (ex_memread),
    .ex_rin       (ex_rin),
    .mem_pc_sel   (mem_pc_sel),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .stall_pc     (stall_pc),
    .stall_ifid   (stall_ifid),
    .flush_ifid   (flush_ifid),
    .stall_idex   (stall_idex),
    .flush_idex   (flush_idex),
    .stall_exmem  (stall_exmem),
    .flush_exmem  (flush_exmem),
    .flush_memwb  (flush_memwb),
    .state_o      (state_o),
    .err_timeout  (err_timeout),
    .stall_cycles (stall_cycles)
  );

  // Control vector order: stall_pc stall_ifid flush_ifid stall_idex flush_idex stall_exmem flush_exmem flush_memwb
  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b1100_1000;
  localparam logic [7:0] C_RD   = 8'b0010_1010;
  localparam logic [7:0] C_SH   = 8'b0010_0000;
  localparam logic [7:0] C_FZ   = 8'b1101_0101;

  typedef struct packed {
    logic [7:0]       ctrl;
    logic [1:0]       st;
    logic             err;
    logic [CNT_W-1:0] cyc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  int unsigned exp_cycles = 0;

  logic [7:0] obs_ctrl;
  assign obs_ctrl = {stall_pc, stall_ifid, flush_ifid, stall_idex,
                     flush_idex, stall_exmem, flush_exmem, flush_memwb};

  task automatic check_out();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs_ctrl === e.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl observed=%b expected=%b", t, obs_ctrl, e.ctrl);
    end
    checks++;
    assert (state_o === e.st) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", t, state_o, e.st);
    end
    checks++;
    assert (err_timeout === e.err) else begin
      errors++;
      $error("FAIL %s err_timeout observed=%b expected=%b", t, err_timeout, e.err);
    end
    checks++;
    assert (stall_cycles === e.cyc) else begin
      errors++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d", t, stall_cycles, e.cyc);
    end
    $display("step %-12s ctrl=%b state=%0d err=%b stall_cycles=%0d",
             t, obs_ctrl, state_o, err_timeout, stall_cycles);
  endtask

  task automatic step(input string tag, input logic [7:0] ctrl,
                      input logic [1:0] st, input logic er);
    exp_t e;
    if (!rst) exp_cycles = 0;
    e.ctrl = ctrl;
    e.st   = st;
    e.err  = er;
    e.cyc  = CNT_W'(exp_cycles);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_out();
    if (ctrl[7] && rst) exp_cycles++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [4:0] rz, input logic rd, input logic wr);
    ex_rz_idx  = rz;
    ex_memread = rd;
    ex_rin     = wr;
  endtask

  task automatic set_id(input logic [4:0] rx, input logic [4:0] ry,
                        input logic urx, input logic ury);
    id_rx_idx  = rx;
    id_ry_idx  = ry;
    id_uses_rx = urx;
    id_uses_ry = ury;
  endtask

  initial begin
    step("reset", C_IDLE, ST_RUN, 1'b0);
    rst = 1'b1;

    // Load-use on Rx, then bubble in EX
    set_ex(5'd3, 1'b1, 1'b1); set_id(5'd3, 5'd9, 1'b1, 1'b0);
    step("lu_rx", C_LU, ST_RUN, 1'b0);
    set_ex(5'd0, 1'b0, 1'b0);
    step("lu_clear", C_IDLE, ST_RUN, 1'b0);
    // Load-use on Ry; then same indices but Ry not read
    set_ex(5'd7, 1'b1, 1'b1); set_id(5'd1, 5'd7, 1'b0, 1'b1);
    step("lu_ry", C_LU, ST_RUN, 1'b0);
    set_id(5'd1, 5'd7, 1'b0, 1'b0);
    step("ry_unused", C_IDLE, ST_RUN, 1'b0);
    // No-hazard boundaries
    set_ex(5'd0, 1'b1, 1'b1); set_id(5'd0, 5'd0, 1'b1, 1'b1);
    step("rz_zero", C_IDLE, ST_RUN, 1'b0);
    set_ex(5'd3, 1'b0, 1'b1); set_id(5'd3, 5'd3, 1'b1, 1'b1);
    step("no_load", C_IDLE, ST_RUN, 1'b0);
    set_ex(5'd3, 1'b1, 1'b0);
    step("no_rin", C_IDLE, ST_RUN, 1'b0);

    // Redirect with a load-use present: redirect wins, then one shadow cycle
    set_ex(5'd3, 1'b1, 1'b1); set_id(5'd3, 5'd0, 1'b1, 1'b0);
    mem_pc_sel = PCSEL_IMM;
    step("redirect", C_RD, ST_RUN, 1'b0);
    mem_pc_sel = PCSEL_PC4; set_ex(5'd0, 1'b0, 1'b0);
    step("shadow", C_SH, ST_BRSHADOW, 1'b0);
    step("post_shadow", C_IDLE, ST_RUN, 1'b0);
    // Redirect inside the shadow reloads it
    mem_pc_sel = PCSEL_REG;
    step("redir_a", C_RD, ST_RUN, 1'b0);
    step("redir_b", C_RD, ST_BRSHADOW, 1'b0);
    mem_pc_sel = PCSEL_PC4;
    step("reload_sh", C_SH, ST_BRSHADOW, 1'b0);
    step("reload_end", C_IDLE, ST_RUN, 1'b0);

    // Memory wait acknowledged after 4 frozen cycles
    mem_req = 1'b1; mem_ack = 1'b0;
    step("wait0", C_FZ, ST_RUN, 1'b0);
    for (int i = 1; i < 4; i++) step("wait_n", C_FZ, ST_MEMWAIT, 1'b0);
    mem_ack = 1'b1;
    step("ack", C_IDLE, ST_MEMWAIT, 1'b0);
    mem_req = 1'b0; mem_ack = 1'b0;
    step("after_ack", C_IDLE, ST_RUN, 1'b0);

    // Timeout after 8 frozen cycles
    mem_req = 1'b1;
    step("to_start", C_FZ, ST_RUN, 1'b0);
    for (int i = 1; i < 8; i++) step("to_wait", C_FZ, ST_MEMWAIT, 1'b0);
    step("to_release", C_IDLE, ST_MEMWAIT, 1'b0);
    mem_req = 1'b0;
    step("to_sticky", C_IDLE, ST_RUN, 1'b1);

    // Freeze beats redirect and load-use; redirect lands in the ack cycle
    set_ex(5'd4, 1'b1, 1'b1); set_id(5'd4, 5'd0, 1'b1, 1'b0);
    mem_pc_sel = PCSEL_IMM; mem_req = 1'b1; mem_ack = 1'b0;
    step("all3_freeze", C_FZ, ST_RUN, 1'b1);
    step("all3_wait", C_FZ, ST_MEMWAIT, 1'b1);
    mem_ack = 1'b1;
    step("all3_ack", C_RD, ST_MEMWAIT, 1'b1);
    mem_req = 1'b0; mem_ack = 1'b0; mem_pc_sel = PCSEL_PC4; set_ex(5'd0, 1'b0, 1'b0);
    step("all3_shadow", C_SH, ST_BRSHADOW, 1'b1);
    mem_req = 1'b1;
    step("sh_freeze", C_FZ, ST_RUN, 1'b1);
    step("mid_wait", C_FZ, ST_MEMWAIT, 1'b1);

    // Asynchronous reset in the middle of a wait
    rst = 1'b0;
    step("async_rst", C_IDLE, ST_RUN, 1'b0);
    mem_req = 1'b0;
    rst = 1'b1;
    step("post_rst", C_IDLE, ST_RUN, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
